// File: rtl/biriscv_branch_pkg.sv
// ----------------------------------------------------------------------------
// biriscv_branch_pkg: shared types for the branch arbiter and its update queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package biriscv_branch_pkg;

  localparam int BRANCH_ARB_DEPTH_DEF = 4;

  typedef struct packed {
    logic        taken;
    logic        ntaken;
    logic        call;
    logic        ret;
    logic        jmp;
    logic [31:0] source;
    logic [31:0] pc;
  } branch_upd_t;

endpackage

`default_nettype wire

// File: rtl/biriscv_branch_fifo.sv
// ----------------------------------------------------------------------------
// biriscv_branch_fifo: 2-write/1-read circular queue of predictor updates
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module biriscv_branch_fifo
  import biriscv_branch_pkg::*;
#(
  parameter int DEPTH = BRANCH_ARB_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push0,
  input  logic                       push1,
  input  branch_upd_t                data0,
  input  branch_upd_t                data1,
  input  logic                       pop,
  output branch_upd_t                head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  branch_upd_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   w_wr_ptr1;
  logic [c_CNT_W-1:0]   r_count;

  // Second write lands after the first one when both are present.
  assign w_wr_ptr1 = r_wr_ptr + c_PTR_W'(push0);

  always_ff @(posedge clk_i) begin
    if (push0) r_mem[r_wr_ptr]  <= data0;
    if (push1) r_mem[w_wr_ptr1] <= data1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(pop);
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(push0) + c_PTR_W'(push1);
      r_count  <= r_count + c_CNT_W'(push0) + c_CNT_W'(push1) - c_CNT_W'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/biriscv_branch_arb.sv
// ----------------------------------------------------------------------------
// biriscv_branch_arb: exec-slot redirect arbitration and predictor update queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module biriscv_branch_arb
  import biriscv_branch_pkg::*;
#(
  parameter int DEPTH = BRANCH_ARB_DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s0_d_request_i,
  input  logic [31:0] s0_d_pc_i,
  input  logic        s1_d_request_i,
  input  logic [31:0] s1_d_pc_i,
  input  logic        s0_request_i,
  input  logic        s0_taken_i,
  input  logic        s0_ntaken_i,
  input  logic        s0_call_i,
  input  logic        s0_ret_i,
  input  logic        s0_jmp_i,
  input  logic [31:0] s0_source_i,
  input  logic [31:0] s0_pc_i,
  input  logic        s1_request_i,
  input  logic        s1_taken_i,
  input  logic        s1_ntaken_i,
  input  logic        s1_call_i,
  input  logic        s1_ret_i,
  input  logic        s1_jmp_i,
  input  logic [31:0] s1_source_i,
  input  logic [31:0] s1_pc_i,
  output logic        fetch_request_o,
  output logic [31:0] fetch_pc_o,
  output logic        squash_s1_o,
  output logic        bp_valid_o,
  input  logic        bp_ready_i,
  output logic        bp_taken_o,
  output logic        bp_ntaken_o,
  output logic        bp_call_o,
  output logic        bp_ret_o,
  output logic        bp_jmp_o,
  output logic [31:0] bp_source_o,
  output logic [31:0] bp_pc_o,
  output logic        stall_o,
  output logic        overflow_o
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  branch_upd_t        w_s0_upd;
  branch_upd_t        w_s1_upd;
  branch_upd_t        w_data0;
  branch_upd_t        w_head;
  logic               w_s0_vld;
  logic               w_s1_vld;
  logic               w_push0;
  logic               w_push1;
  logic               w_pop;
  logic               w_drop;
  logic [c_CNT_W-1:0] w_count;
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_CNT_W:0]   w_free;
  logic               r_fetch_request;
  logic [31:0]        r_fetch_pc;
  logic               r_overflow;
  logic               r_stall;

  assign squash_s1_o = s0_d_request_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_request <= 1'b0;
      r_fetch_pc      <= '0;
    end else begin
      r_fetch_request <= s0_d_request_i | s1_d_request_i;
      if (s0_d_request_i)      r_fetch_pc <= s0_d_pc_i;
      else if (s1_d_request_i) r_fetch_pc <= s1_d_pc_i;
    end
  end

  assign fetch_request_o = r_fetch_request;
  assign fetch_pc_o      = r_fetch_pc;

  assign w_s0_upd = '{taken: s0_taken_i, ntaken: s0_ntaken_i, call: s0_call_i,
                      ret: s0_ret_i, jmp: s0_jmp_i, source: s0_source_i, pc: s0_pc_i};
  assign w_s1_upd = '{taken: s1_taken_i, ntaken: s1_ntaken_i, call: s1_call_i,
                      ret: s1_ret_i, jmp: s1_jmp_i, source: s1_source_i, pc: s1_pc_i};

  // A taken slot 0 branch puts slot 1 on the wrong path.
  assign w_s0_vld = s0_request_i;
  assign w_s1_vld = s1_request_i & ~(s0_request_i & s0_taken_i);

  assign w_pop  = bp_valid_o & bp_ready_i;
  assign w_free = (c_CNT_W+1)'(DEPTH) - {1'b0, w_count} + (c_CNT_W+1)'(w_pop);

  // Records are compacted so the oldest valid one always uses write port 0.
  assign w_push0 = (w_s0_vld | w_s1_vld) & (w_free != '0);
  assign w_push1 = w_s0_vld & w_s1_vld & (w_free >= (c_CNT_W+1)'(2));
  assign w_data0 = w_s0_vld ? w_s0_upd : w_s1_upd;
  assign w_drop  = ((w_s0_vld | w_s1_vld) & ~w_push0) | (w_s0_vld & w_s1_vld & ~w_push1);

  assign w_count_next = w_count + c_CNT_W'(w_push0) + c_CNT_W'(w_push1) - c_CNT_W'(w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      r_stall    <= w_count_next > c_CNT_W'(DEPTH - 2);
    end
  end

  assign overflow_o = r_overflow;
  assign stall_o    = r_stall;

  biriscv_branch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push0 (w_push0),
    .push1 (w_push1),
    .data0 (w_data0),
    .data1 (w_s1_upd),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_count)
  );

  assign bp_valid_o  = (w_count != '0);
  assign bp_taken_o  = w_head.taken;
  assign bp_ntaken_o = w_head.ntaken;
  assign bp_call_o   = w_head.call;
  assign bp_ret_o    = w_head.ret;
  assign bp_jmp_o    = w_head.jmp;
  assign bp_source_o = w_head.source;
  assign bp_pc_o     = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_biriscv_branch_arb.sv
// ----------------------------------------------------------------------------
// tb_biriscv_branch_arb: directed self-checking bench for biriscv_branch_arb
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_biriscv_branch_arb;
  import biriscv_branch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s0_d_request_i, s1_d_request_i;
  logic [31:0] s0_d_pc_i, s1_d_pc_i;
  logic        s0_request_i, s0_taken_i, s0_ntaken_i, s0_call_i, s0_ret_i, s0_jmp_i;
  logic        s1_request_i, s1_taken_i, s1_ntaken_i, s1_call_i, s1_ret_i, s1_jmp_i;
  logic [31:0] s0_source_i, s0_pc_i, s1_source_i, s1_pc_i;
  logic        fetch_request_o, squash_s1_o, bp_valid_o, bp_ready_i;
  logic [31:0] fetch_pc_o, bp_source_o, bp_pc_o;
  logic        bp_taken_o, bp_ntaken_o, bp_call_o, bp_ret_o, bp_jmp_o;
  logic        stall_o, overflow_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  biriscv_branch_arb #(.DEPTH(4)) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .s0_d_request_i (s0_d_request_i), .s0_d_pc_i (s0_d_pc_i),
    .s1_d_request_i (s1_d_request_i), .s1_d_pc_i (s1_d_pc_i),
    .s0_request_i (s0_request_i), .s0_taken_i (s0_taken_i), .s0_ntaken_i (s0_ntaken_i),
    .s0_call_i (s0_call_i), .s0_ret_i (s0_ret_i), .s0_jmp_i (s0_jmp_i),
    .s0_source_i (s0_source_i), .s0_pc_i (s0_pc_i),
    .s1_request_i (s1_request_i), .s1_taken_i (s1_taken_i), .s1_ntaken_i (s1_ntaken_i),
    .s1_call_i (s1_call_i), .s1_ret_i (s1_ret_i), .s1_jmp_i (s1_jmp_i),
    .s1_source_i (s1_source_i), .s1_pc_i (s1_pc_i),
    .fetch_request_o (fetch_request_o), .fetch_pc_o (fetch_pc_o), .squash_s1_o (squash_s1_o),
    .bp_valid_o (bp_valid_o), .bp_ready_i (bp_ready_i),
    .bp_taken_o (bp_taken_o), .bp_ntaken_o (bp_ntaken_o), .bp_call_o (bp_call_o),
    .bp_ret_o (bp_ret_o), .bp_jmp_o (bp_jmp_o),
    .bp_source_o (bp_source_o), .bp_pc_o (bp_pc_o),
    .stall_o (stall_o), .overflow_o (overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_recs();
    s0_request_i = 0; s0_taken_i = 0; s0_ntaken_i = 0; s0_call_i = 0; s0_ret_i = 0; s0_jmp_i = 0;
    s1_request_i = 0; s1_taken_i = 0; s1_ntaken_i = 0; s1_call_i = 0; s1_ret_i = 0; s1_jmp_i = 0;
    s0_source_i = '0; s0_pc_i = '0; s1_source_i = '0; s1_pc_i = '0;
  endtask

  task automatic clear_redir();
    s0_d_request_i = 0; s1_d_request_i = 0; s0_d_pc_i = '0; s1_d_pc_i = '0;
  endtask

  task automatic rec(input bit slot, input logic [31:0] src, input logic tk);
    if (!slot) begin
      s0_request_i = 1; s0_source_i = src; s0_pc_i = src + 32'h100;
      s0_taken_i = tk; s0_ntaken_i = ~tk;
    end else begin
      s1_request_i = 1; s1_source_i = src; s1_pc_i = src + 32'h100;
      s1_taken_i = tk; s1_ntaken_i = ~tk;
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] src);
    check({tag, "_valid"}, 32'(bp_valid_o), 32'd1);
    check({tag, "_source"}, bp_source_o, src);
    check({tag, "_pc"}, bp_pc_o, src + 32'h100);
  endtask

  initial begin
    rst_i = 1'b1;
    bp_ready_i = 1'b0;
    clear_recs();
    clear_redir();
    tick();
    tick();
    check("rst_fetch_req", 32'(fetch_request_o), 32'd0);
    check("rst_fetch_pc", fetch_pc_o, 32'd0);
    check("rst_bp_valid", 32'(bp_valid_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_count", 32'(dut.u_fifo.count), 32'd0);
    rst_i = 1'b0;
    tick();

    // Slot 1 redirect alone, then the held target.
    s1_d_request_i = 1; s1_d_pc_i = 32'h3C;
    #1 check("s1_only_squash", 32'(squash_s1_o), 32'd0);
    tick();
    clear_redir();
    check("s1_fetch_req", 32'(fetch_request_o), 32'd1);
    check("s1_fetch_pc", fetch_pc_o, 32'h3C);
    tick();
    check("s1_fetch_req_pulse", 32'(fetch_request_o), 32'd0);
    check("s1_fetch_pc_hold", fetch_pc_o, 32'h3C);

    // Both slots redirect: slot 0 wins and squashes slot 1.
    s0_d_request_i = 1; s0_d_pc_i = 32'h100;
    s1_d_request_i = 1; s1_d_pc_i = 32'h200;
    #1 check("both_squash", 32'(squash_s1_o), 32'd1);
    tick();
    clear_redir();
    check("both_fetch_req", 32'(fetch_request_o), 32'd1);
    check("both_fetch_pc", fetch_pc_o, 32'h100);
    tick();
    check("both_fetch_req_pulse", 32'(fetch_request_o), 32'd0);

    // Two not-taken records drain in program order.
    bp_ready_i = 1'b1;
    rec(0, 32'h10, 1'b0);
    rec(1, 32'h14, 1'b0);
    tick();
    clear_recs();
    check_head("nt_head0", 32'h10);
    check("nt_head0_ntaken", 32'(bp_ntaken_o), 32'd1);
    tick();
    check_head("nt_head1", 32'h14);
    tick();
    check("nt_empty", 32'(bp_valid_o), 32'd0);

    // Taken slot 0 drops slot 1.
    rec(0, 32'h20, 1'b1);
    rec(1, 32'h24, 1'b0);
    tick();
    clear_recs();
    check_head("tk_head", 32'h20);
    check("tk_taken", 32'(bp_taken_o), 32'd1);
    tick();
    check("tk_only_one", 32'(bp_valid_o), 32'd0);

    // Fill under back-pressure, overflow, then drain.
    bp_ready_i = 1'b0;
    rec(0, 32'hA0, 1'b0); rec(1, 32'hA4, 1'b0);
    tick();
    clear_recs();
    check("fill2_count", 32'(dut.u_fifo.count), 32'd2);
    check("fill2_stall", 32'(stall_o), 32'd0);
    rec(0, 32'hA8, 1'b0); rec(1, 32'hAC, 1'b0);
    tick();
    clear_recs();
    check("fill4_count", 32'(dut.u_fifo.count), 32'd4);
    check("fill4_stall", 32'(stall_o), 32'd1);
    check("fill4_overflow", 32'(overflow_o), 32'd0);
    rec(0, 32'hB0, 1'b0);
    tick();
    clear_recs();
    check("ovf_pulse", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(dut.u_fifo.count), 32'd4);
    check_head("ovf_head_stable", 32'hA0);
    tick();
    check("ovf_pulse_end", 32'(overflow_o), 32'd0);
    bp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check_head($sformatf("drain%0d", i), 32'hA0 + 32'(4 * i));
      tick();
    end
    check("drain_empty", 32'(bp_valid_o), 32'd0);
    check("drain_stall", 32'(stall_o), 32'd0);

    // Full queue with pop plus single push each cycle: three pointer passes.
    bp_ready_i = 1'b0;
    rec(0, 32'hC0, 1'b0); rec(1, 32'hC4, 1'b0);
    tick();
    clear_recs();
    rec(0, 32'hC8, 1'b0); rec(1, 32'hCC, 1'b0);
    tick();
    clear_recs();
    exp_q = '{32'hC0, 32'hC4, 32'hC8, 32'hCC};
    bp_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rec(0, 32'hD0 + 32'(4 * k), 1'b0);
      #1 check_head($sformatf("wrap%0d", k), exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back(32'hD0 + 32'(4 * k));
      tick();
      check($sformatf("wrap%0d_overflow", k), 32'(overflow_o), 32'd0);
      check($sformatf("wrap%0d_count", k), 32'(dut.u_fifo.count), 32'd4);
    end
    clear_recs();
    for (int i = 0; i < 4; i++) begin
      #1 check_head($sformatf("wrap_drain%0d", i), exp_q[i]);
      tick();
    end
    check("wrap_empty", 32'(bp_valid_o), 32'd0);

    // Asynchronous reset with entries queued and a redirect in flight.
    bp_ready_i = 1'b0;
    rec(0, 32'hE0, 1'b0); rec(1, 32'hE4, 1'b0);
    tick();
    clear_recs();
    rec(0, 32'hE8, 1'b0);
    s0_d_request_i = 1; s0_d_pc_i = 32'h500;
    tick();
    clear_recs();
    clear_redir();
    check("pre_rst_count", 32'(dut.u_fifo.count), 32'd3);
    check("pre_rst_fetch_req", 32'(fetch_request_o), 32'd1);
    check("pre_rst_fetch_pc", fetch_pc_o, 32'h500);
    check("pre_rst_stall", 32'(stall_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_fetch_req", 32'(fetch_request_o), 32'd0);
    check("arst_fetch_pc", fetch_pc_o, 32'd0);
    check("arst_bp_valid", 32'(bp_valid_o), 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_overflow", 32'(overflow_o), 32'd0);
    check("arst_count", 32'(dut.u_fifo.count), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    check("post_rst_bp_valid", 32'(bp_valid_o), 32'd0);
    check("post_rst_fetch_req", 32'(fetch_request_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
